// File: rtl/main_control_fsm.sv
// Multi-cycle main controller for the RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives the datapath selects and write enables.
module main_control_fsm (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] imm_src_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready_i;
        pc_update  = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready_i) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format depends only on the opcode so the extender settles early.
  always_comb begin
    case (op_i)
      OP_SW:   imm_src_o = 2'b01;
      OP_BEQ:  imm_src_o = 2'b10;
      OP_JAL:  imm_src_o = 2'b11;
      default: imm_src_o = 2'b00;
    endcase
  end

  // Enables are masked by reset so an in-flight store or write dies instantly.
  assign pc_write_o   = rst_ni & (pc_update | (branch & zero_i));
  assign mem_write_o  = rst_ni & mem_write;
  assign ir_write_o   = rst_ni & ir_write;
  assign reg_write_o  = rst_ni & reg_write;
  assign instr_done_o = rst_ni & instr_done;
  assign illegal_o    = rst_ni & illegal;
  assign adr_src_o    = adr_src;
  assign result_src_o = result_src;
  assign alu_src_a_o  = alu_src_a;
  assign alu_src_b_o  = alu_src_b;
  assign alu_op_o     = alu_op;
  assign state_o      = state_q;

endmodule
